// File: rtl/mem_map_io_ctrl_if.sv
// Processor data-port bus between the CPU and mem_map_io_ctrl.
// The master drives address/strobes/write data; the slave returns read data and the I/O valid strobe.
interface mem_map_io_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] proc_wr_data;
  logic              proc_rd;
  logic              proc_wr;
  logic [DATA_W-1:0] proc_rd_data;
  logic              io_rd_valid;

  modport master (
    output addr, proc_wr_data, proc_rd, proc_wr,
    input  proc_rd_data, io_rd_valid
  );

  modport slave (
    input  addr, proc_wr_data, proc_rd, proc_wr,
    output proc_rd_data, io_rd_valid
  );
endinterface

// File: rtl/mem_map_io_ctrl.sv
// Memory-mapped I/O controller: memory pass-through, UART FIFO access, switches, LEDs, status.
// Optional compare/interrupt timer is built when MEM_MAP_IO_TIMER_EN is defined.
module mem_map_io_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int IO_BIT     = 23,
  parameter int LED_W      = 8,
  parameter int SW_W       = 3,
  parameter int CNT_W      = 11,
  parameter int FIFO_DEPTH = 1024,
  parameter int TIMER_W    = 16,
  parameter int PRESCALE   = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_map_io_ctrl_if.slave   bus,
  input  logic [DATA_W-1:0]  i_mem_rd_data,
  input  logic [7:0]         i_uart_rd_data,
  input  logic [CNT_W-1:0]   i_uart_tx_count,
  input  logic [CNT_W-1:0]   i_uart_rx_count,
  input  logic [SW_W-1:0]    i_switches,
  output logic               o_mem_rd,
  output logic               o_mem_wr,
  output logic               o_uart_rd,
  output logic               o_uart_wr,
  output logic [7:0]         o_uart_wr_data,
  output logic [LED_W-1:0]   o_leds,
  output logic               o_irq
);

  localparam logic [CNT_W:0] DEPTH = (CNT_W+1)'(FIFO_DEPTH);

  logic              w_io;
  logic [IO_BIT-1:0] w_offset;
  logic              w_io_wr;
  logic              w_io_rd;
  logic              w_rx_nonempty;
  logic              w_tx_full;
  logic [7:0]        w_wr_sel;
  logic [DATA_W-1:0] w_rd_mux;
  logic [1:0]        w_status_hi;
  logic [DATA_W-1:0] w_count_rd;
  logic [DATA_W-1:0] w_compare_rd;
  logic              w_unused;

  logic [LED_W-1:0]  r_leds;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [SW_W-1:0]   r_sw_meta;
  logic [SW_W-1:0]   r_sw_sync;

  assign w_io          = bus.addr[IO_BIT];
  assign w_offset      = bus.addr[IO_BIT-1:0];
  // A simultaneous read+write is treated as a write only
  assign w_io_wr       = w_io & bus.proc_wr;
  assign w_io_rd       = w_io & bus.proc_rd & ~bus.proc_wr;
  assign w_rx_nonempty = (i_uart_rx_count != '0);
  assign w_tx_full     = ({1'b0, i_uart_tx_count} >= DEPTH);

  assign o_mem_rd       = ~w_io & bus.proc_rd;
  assign o_mem_wr       = ~w_io & bus.proc_wr;
  assign o_uart_wr      = w_io_wr & (w_offset == '0) & ~w_tx_full;
  assign o_uart_rd      = w_io_rd & (w_offset == '0) & w_rx_nonempty;
  assign o_uart_wr_data = bus.proc_wr_data[7:0];
  assign o_leds         = r_leds;

  assign bus.proc_rd_data = r_rd_valid ? r_rd_data : i_mem_rd_data;
  assign bus.io_rd_valid  = r_rd_valid;

  assign w_unused = &{1'b0, bus.addr[ADDR_W-1:IO_BIT+1], bus.proc_wr_data};

  always_comb begin
    w_wr_sel = '0;
    for (int k = 0; k < 8; k++) begin
      w_wr_sel[k] = w_io_wr && (w_offset == IO_BIT'(k));
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_offset)
      IO_BIT'(0): w_rd_mux = w_rx_nonempty ? DATA_W'(i_uart_rd_data) : '0;
      IO_BIT'(1): w_rd_mux = DATA_W'(r_sw_sync);
      IO_BIT'(2): w_rd_mux = DATA_W'(i_uart_tx_count);
      IO_BIT'(3): w_rd_mux = DATA_W'(i_uart_rx_count);
      IO_BIT'(4): w_rd_mux = DATA_W'(r_leds);
      IO_BIT'(5): w_rd_mux = DATA_W'({w_status_hi, w_tx_full, w_rx_nonempty});
      IO_BIT'(6): w_rd_mux = w_count_rd;
      IO_BIT'(7): w_rd_mux = w_compare_rd;
      default:    w_rd_mux = '0;
    endcase
  end

  // Read data is captured at the access edge and presented for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_leds     <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
    end else begin
      r_rd_valid <= w_io_rd;
      if (w_io_rd) r_rd_data <= w_rd_mux;
      if (w_wr_sel[4]) r_leds <= bus.proc_wr_data[LED_W-1:0];
      r_sw_meta <= i_switches;
      r_sw_sync <= r_sw_meta;
    end
  end

`ifdef MEM_MAP_IO_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]      r_presc;
  logic [TIMER_W-1:0] r_count;
  logic [TIMER_W-1:0] r_compare;
  logic               r_pending;
  logic               r_irq_en;
  logic               w_tick;
  logic               w_match;

  assign w_tick       = (r_presc == PW'(PRESCALE-1));
  assign w_match      = w_tick & (r_count == r_compare);
  assign w_status_hi  = {r_irq_en, r_pending};
  assign w_count_rd   = DATA_W'(r_count);
  assign w_compare_rd = DATA_W'(r_compare);
  assign o_irq        = r_pending & r_irq_en;

  // Software load of the count beats a tick; a match beats a software clear of pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_compare <= '1;
      r_pending <= 1'b0;
      r_irq_en  <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_wr_sel[6])  r_count <= bus.proc_wr_data[TIMER_W-1:0];
      else if (w_match) r_count <= '0;
      else if (w_tick)  r_count <= r_count + 1'b1;
      if (w_wr_sel[7]) r_compare <= bus.proc_wr_data[TIMER_W-1:0];
      if (w_wr_sel[5]) r_irq_en <= bus.proc_wr_data[3];
      if (w_match) r_pending <= 1'b1;
      else if (w_wr_sel[5] && bus.proc_wr_data[2]) r_pending <= 1'b0;
    end
  end
`else
  assign w_status_hi  = 2'b00;
  assign w_count_rd   = '0;
  assign w_compare_rd = '0;
  assign o_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_map_io_ctrl.sv
// Self-checking bench for mem_map_io_ctrl: randomized accesses against a behavioural model of the register map.
// Timer checks follow MEM_MAP_IO_TIMER_EN so the same bench covers both builds.
module tb_mem_map_io_ctrl;

  localparam int PRESCALE_TB = 2;
  localparam logic [31:0] IO_BASE = 32'h0080_0000;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_rd_data;
  logic [7:0]  uart_rd_data;
  logic [10:0] tx_count;
  logic [10:0] rx_count;
  logic [2:0]  switches;
  logic        mem_rd, mem_wr, uart_rd, uart_wr, irq;
  logic [7:0]  uart_wr_data;
  logic [7:0]  leds;

  int total = 0;
  int bad = 0;
  int edges = 0;
  logic [7:0] m_leds;

  mem_map_io_ctrl_if #(.ADDR_W(32), .DATA_W(16)) bus ();

  mem_map_io_ctrl #(.PRESCALE(PRESCALE_TB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .i_mem_rd_data(mem_rd_data), .i_uart_rd_data(uart_rd_data),
    .i_uart_tx_count(tx_count), .i_uart_rx_count(rx_count),
    .i_switches(switches),
    .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_uart_rd(uart_rd), .o_uart_wr(uart_wr),
    .o_uart_wr_data(uart_wr_data), .o_leds(leds), .o_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else edges <= edges + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [31:0] a, input logic rd, input logic wr, input logic [15:0] wd);
    bus.addr = a;
    bus.proc_rd = rd;
    bus.proc_wr = wr;
    bus.proc_wr_data = wd;
  endtask

  task automatic idle();
    applyStimulus(32'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input int off, input logic [15:0] wd);
    applyStimulus(IO_BASE | 32'(off), 1'b0, 1'b1, wd);
    tick();
    idle();
  endtask

  task automatic io_read(input int off, output logic [15:0] d, output logic v);
    applyStimulus(IO_BASE | 32'(off), 1'b1, 1'b0, 16'h0);
    tick();
    idle();
    #1;
    d = bus.proc_rd_data;
    v = bus.io_rd_valid;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_leds = 8'h00;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic v;
    logic [15:0] exp_cmp;
    #2;
    total++; if ({leds, bus.io_rd_valid, irq} !== 10'b0) begin bad++; $display("[TB] FAIL reset_outputs: got %h expected 0", {leds, bus.io_rd_valid, irq}); end
    mem_rd_data = 16'h1234;
    applyStimulus(32'h10, 1'b1, 1'b0, 16'h0);
    #1;
    total++; if ({mem_rd, bus.proc_rd_data} !== {1'b1, 16'h1234}) begin bad++; $display("[TB] FAIL reset_mem_path: got %b/%h expected 1/1234", mem_rd, bus.proc_rd_data); end
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_leds = 8'h00;
    io_read(5, d, v);
    total++; if ({v, d} !== {1'b1, 16'h0}) begin bad++; $display("[TB] FAIL reset_status: got %b/%h expected 1/0000", v, d); end
`ifdef MEM_MAP_IO_TIMER_EN
    exp_cmp = 16'hFFFF;
`else
    exp_cmp = 16'h0000;
`endif
    io_read(7, d, v);
    total++; if (d !== exp_cmp) begin bad++; $display("[TB] FAIL reset_compare: got %h expected %h", d, exp_cmp); end
  endtask

  task automatic test_mem_pass();
    logic [31:0] a;
    logic rd, wr;
    logic [15:0] md;
    idle();
    tick();
    mem_rd_data = 16'hBEEF;
    applyStimulus(32'h10, 1'b1, 1'b0, 16'h0);
    #1;
    total++; if ({mem_rd, bus.io_rd_valid, bus.proc_rd_data} !== {1'b1, 1'b0, 16'hBEEF}) begin bad++; $display("[TB] FAIL mem_beef: got %b%b/%h expected 10/beef", mem_rd, bus.io_rd_valid, bus.proc_rd_data); end
    tick();
    for (int i = 0; i < 8; i++) begin
      a = $urandom & ~IO_BASE;
      rd = 1'($urandom);
      wr = 1'($urandom);
      md = 16'($urandom);
      mem_rd_data = md;
      applyStimulus(a, rd, wr, 16'($urandom));
      #1;
      total++; if ({mem_rd, mem_wr, uart_rd, uart_wr, bus.io_rd_valid} !== {rd, wr, 3'b000}) begin bad++; $display("[TB] FAIL mem_strobes: got %b expected %b", {mem_rd, mem_wr, uart_rd, uart_wr, bus.io_rd_valid}, {rd, wr, 3'b000}); end
      total++; if (bus.proc_rd_data !== md) begin bad++; $display("[TB] FAIL mem_data: got %h expected %h", bus.proc_rd_data, md); end
      tick();
    end
    idle();
    total++; if (leds !== m_leds) begin bad++; $display("[TB] FAIL mem_no_side_effect: got %h expected %h", leds, m_leds); end
  endtask

  task automatic test_leds();
    logic [15:0] d, wd;
    logic v;
    for (int i = 0; i < 5; i++) begin
      wd = (i == 0) ? 16'h00A5 : 16'($urandom);
      io_write(4, wd);
      m_leds = wd[7:0];
      total++; if (leds !== m_leds) begin bad++; $display("[TB] FAIL led_write: got %h expected %h", leds, m_leds); end
      io_read(4, d, v);
      total++; if ({v, d} !== {1'b1, 8'h00, m_leds}) begin bad++; $display("[TB] FAIL led_readback: got %b/%h expected 1/%h", v, d, {8'h00, m_leds}); end
      tick();
      total++; if (bus.io_rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL valid_one_cycle: got %b expected 0", bus.io_rd_valid); end
    end
  endtask

  task automatic test_uart();
    logic [15:0] d, wd, exp_d;
    logic v;
    for (int i = 0; i < 6; i++) begin
      rx_count = (i == 0) ? 11'd0 : (i == 1) ? 11'd3 : (($urandom % 3) == 0) ? 11'd0 : 11'(1 + $urandom % 1024);
      uart_rd_data = (i == 1) ? 8'h41 : 8'($urandom);
      exp_d = (rx_count != 0) ? {8'h00, uart_rd_data} : 16'h0;
      applyStimulus(IO_BASE, 1'b1, 1'b0, 16'h0);
      #1;
      total++; if (uart_rd !== (rx_count != 0)) begin bad++; $display("[TB] FAIL uart_pop: got %b expected %b", uart_rd, (rx_count != 0)); end
      tick();
      idle();
      #1;
      total++; if ({bus.io_rd_valid, bus.proc_rd_data, uart_rd} !== {1'b1, exp_d, 1'b0}) begin bad++; $display("[TB] FAIL uart_rd_data: got %b/%h/%b expected 1/%h/0", bus.io_rd_valid, bus.proc_rd_data, uart_rd, exp_d); end
    end
    for (int i = 0; i < 6; i++) begin
      tx_count = (i == 0) ? 11'd1024 : (i == 1) ? 11'd5 : (($urandom % 3) == 0) ? 11'd1024 : 11'($urandom % 1024);
      wd = 16'($urandom);
      applyStimulus(IO_BASE, 1'b0, 1'b1, wd);
      #1;
      total++; if ({uart_wr, uart_wr_data} !== {(tx_count < 1024), wd[7:0]}) begin bad++; $display("[TB] FAIL uart_push: got %b/%h expected %b/%h", uart_wr, uart_wr_data, (tx_count < 1024), wd[7:0]); end
      tick();
      idle();
    end
    rx_count = 11'd3;
    tx_count = 11'd5;
    applyStimulus(IO_BASE, 1'b1, 1'b1, 16'h0055);
    #1;
    total++; if ({uart_rd, uart_wr} !== 2'b01) begin bad++; $display("[TB] FAIL rdwr_together: got %b expected 01", {uart_rd, uart_wr}); end
    tick();
    idle();
    #1;
    total++; if (bus.io_rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL rdwr_no_valid: got %b expected 0", bus.io_rd_valid); end
  endtask

  task automatic test_io_regs();
    logic [15:0] d, exp_s;
    logic v;
    for (int i = 0; i < 4; i++) begin
      tx_count = (i == 0) ? 11'd1024 : 11'($urandom % 1025);
      rx_count = (i == 1) ? 11'd0 : 11'($urandom % 1025);
      io_read(2, d, v);
      total++; if (d !== {5'b0, tx_count}) begin bad++; $display("[TB] FAIL tx_count: got %h expected %h", d, {5'b0, tx_count}); end
      io_read(3, d, v);
      total++; if (d !== {5'b0, rx_count}) begin bad++; $display("[TB] FAIL rx_count: got %h expected %h", d, {5'b0, rx_count}); end
      exp_s = {14'b0, (tx_count == 11'd1024), (rx_count != 0)};
      io_read(5, d, v);
      total++; if (d !== exp_s) begin bad++; $display("[TB] FAIL status: got %h expected %h", d, exp_s); end
    end
  endtask

  task automatic test_switches();
    logic [15:0] d;
    logic v;
    logic [2:0] old_sw, new_sw;
    old_sw = switches;
    for (int i = 0; i < 4; i++) begin
      new_sw = old_sw ^ 3'(1 + $urandom % 7);
      switches = new_sw;
      tick();
      io_read(1, d, v);
      total++; if (d !== {13'b0, old_sw}) begin bad++; $display("[TB] FAIL sw_early: got %h expected %h", d, {13'b0, old_sw}); end
      io_read(1, d, v);
      total++; if (d !== {13'b0, new_sw}) begin bad++; $display("[TB] FAIL sw_synced: got %h expected %h", d, {13'b0, new_sw}); end
      old_sw = new_sw;
    end
  endtask

  task automatic test_unmapped();
    logic [15:0] d;
    logic v;
    int off;
    for (int i = 0; i < 4; i++) begin
      off = 8 + int'($urandom % ((1 << 23) - 8));
      io_write(off, 16'($urandom));
      io_read(off, d, v);
      total++; if ({v, d} !== {1'b1, 16'h0}) begin bad++; $display("[TB] FAIL unmapped_read: got %b/%h expected 1/0000", v, d); end
      total++; if (leds !== m_leds) begin bad++; $display("[TB] FAIL unmapped_write: got %h expected %h", leds, m_leds); end
    end
  endtask

  task automatic test_back_to_back();
    int offs[5];
    logic [15:0] exps[5];
    tx_count = 11'($urandom % 1024);
    rx_count = 11'(1 + $urandom % 1000);
    uart_rd_data = 8'($urandom);
    offs = '{4, 2, 3, 1, 0};
    exps = '{{8'h00, m_leds}, {5'b0, tx_count}, {5'b0, rx_count}, {13'b0, switches}, {8'h00, uart_rd_data}};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(IO_BASE | 32'(offs[i]), 1'b1, 1'b0, 16'h0);
      tick();
      total++; if ({bus.io_rd_valid, bus.proc_rd_data} !== {1'b1, exps[i]}) begin bad++; $display("[TB] FAIL b2b_%0d: got %b/%h expected 1/%h", i, bus.io_rd_valid, bus.proc_rd_data, exps[i]); end
    end
    idle();
    tick();
    total++; if (bus.io_rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_end: got %b expected 0", bus.io_rd_valid); end
  endtask

  task automatic test_timer();
    logic [15:0] d, wd, flags;
    logic v;
    int target;
    flags = {14'b0, (tx_count == 11'd1024), (rx_count != 0)};
`ifdef MEM_MAP_IO_TIMER_EN
    do_reset();
    applyStimulus(IO_BASE | 32'd7, 1'b0, 1'b1, 16'd3);
    tick();
    applyStimulus(IO_BASE | 32'd5, 1'b0, 1'b1, 16'h0008);
    tick();
    idle();
    target = (3 + 1) * PRESCALE_TB;
    while (edges < target - 1) tick();
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_before_match: got %b expected 0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_at_match: got %b expected 1", irq); end
    io_write(5, 16'h000C);
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_clear: got %b expected 0", irq); end
    target = target + (3 + 1) * PRESCALE_TB;
    while (edges < target - 1) tick();
    io_write(5, 16'h000C);
    #1;
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL clear_vs_set: got %b expected 1", irq); end
    io_read(5, d, v);
    total++; if (d !== (flags | 16'h000C)) begin bad++; $display("[TB] FAIL status_irq: got %h expected %h", d, flags | 16'h000C); end
    while (((edges + 1) % PRESCALE_TB) != 0) tick();
    wd = 16'(100 + $urandom % 100);
    io_write(6, wd);
    io_read(6, d, v);
    total++; if (d !== wd) begin bad++; $display("[TB] FAIL count_load: got %h expected %h", d, wd); end
    wd = 16'($urandom);
    io_write(7, wd);
    io_read(7, d, v);
    total++; if (d !== wd) begin bad++; $display("[TB] FAIL compare_rw: got %h expected %h", d, wd); end
`else
    io_write(6, 16'($urandom));
    io_write(7, 16'($urandom));
    io_read(6, d, v);
    total++; if ({v, d} !== {1'b1, 16'h0}) begin bad++; $display("[TB] FAIL count_off: got %b/%h expected 1/0000", v, d); end
    io_read(7, d, v);
    total++; if (d !== 16'h0) begin bad++; $display("[TB] FAIL compare_off: got %h expected 0000", d); end
    io_write(5, 16'h000C);
    io_read(5, d, v);
    total++; if (d !== flags) begin bad++; $display("[TB] FAIL status_off: got %h expected %h", d, flags); end
    target = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (irq !== 1'b0) target++;
    end
    total++; if (target !== 0) begin bad++; $display("[TB] FAIL irq_tied: got %0d high cycles expected 0", target); end
`endif
  endtask

  task automatic test_reset_mid();
    io_write(4, 16'h00FF);
    m_leds = 8'hFF;
    total++; if (leds !== 8'hFF) begin bad++; $display("[TB] FAIL leds_ff: got %h expected ff", leds); end
    applyStimulus(IO_BASE | 32'd4, 1'b1, 1'b0, 16'h0);
    tick();
    rst_n = 1'b0;
    m_leds = 8'h00;
    #1;
    total++; if ({leds, bus.io_rd_valid, irq} !== 10'b0) begin bad++; $display("[TB] FAIL reset_mid: got %h expected 0", {leds, bus.io_rd_valid, irq}); end
    applyStimulus(32'h10, 1'b1, 1'b0, 16'h0);
    #1;
    total++; if (mem_rd !== 1'b1) begin bad++; $display("[TB] FAIL strobe_in_reset: got %b expected 1", mem_rd); end
    applyStimulus(IO_BASE | 32'd4, 1'b1, 1'b0, 16'h0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    total++; if ({bus.io_rd_valid, leds} !== 9'b0) begin bad++; $display("[TB] FAIL no_valid_after_reset: got %b/%h expected 0/00", bus.io_rd_valid, leds); end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_rd_data = 16'h0;
    uart_rd_data = 8'h0;
    tx_count = 11'd0;
    rx_count = 11'd0;
    switches = 3'b000;
    m_leds = 8'h00;
    idle();
    test_reset();
    test_mem_pass();
    test_leds();
    test_uart();
    test_io_regs();
    test_switches();
    test_unmapped();
    test_back_to_back();
    test_timer();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_map_io_ctrl.md
# mem_map_io_ctrl

Registered, parametrised memory-mapped I/O controller between the processor data port, main memory, the UART FIFOs, switches and LEDs. Decodes the I/O window bit, passes memory accesses through with no added latency, and serves I/O reads from a registered read-data path with a valid strobe. Adds features the combinational decoder lacked: a readable LED register, synchronised switches, a status register and an optional compare/interrupt timer.

## Interface
- ADDR_W, 32, processor address width
- DATA_W, 16, processor data width
- IO_BIT, 23, address bit selecting the I/O window
- LED_W, 8, LED register width (≤ DATA_W)
- SW_W, 3, switch input width (≤ DATA_W)
- CNT_W, 11, UART FIFO count width
- FIFO_DEPTH, 1024, UART TX FIFO depth (full when count == FIFO_DEPTH)
- TIMER_W, 16, timer width (≤ DATA_W)
- PRESCALE, 50, clocks per timer tick (≥ 1)
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_W  processor address
- proc_wr_data  in  DATA_W  write data
- proc_rd, proc_wr  in  1  single-cycle access strobes
- mem_rd_data  in  DATA_W  memory read data
- uart_rd_data  in  8  RX FIFO head (show-ahead)
- uart_tx_count, uart_rx_count  in  CNT_W  FIFO occupancy
- switches  in  SW_W  asynchronous switch inputs
- mem_rd, mem_wr  out  1  memory strobes (combinational)
- uart_rd, uart_wr  out  1  FIFO pop/push (combinational)
- uart_wr_data  out  8  proc_wr_data[7:0]
- proc_rd_data  out  DATA_W  read data to processor
- io_rd_valid  out  1  I/O read data valid
- leds  out  LED_W  LED register
- irq  out  1  timer interrupt request

## Operation
- addr[IO_BIT]=0: mem_rd/mem_wr = proc_rd/proc_wr; proc_rd_data = mem_rd_data; no I/O side effects.
- addr[IO_BIT]=1: offset = addr[IO_BIT-1:0]. proc_rd and proc_wr together: write performed, read suppressed (no pop, no io_rd_valid).
- Offset 0 UART: write pushes (uart_wr) only if uart_tx_count < FIFO_DEPTH, else dropped. Read pops (uart_rd) only if uart_rx_count ≠ 0, returns {0, uart_rd_data}; empty read returns 0 with no pop.
- Offset 1: synchronised switches, zero-extended. Offsets 2/3: tx/rx counts, zero-extended.
- Offset 4: LED register R/W, write takes proc_wr_data[LED_W-1:0].
- Offset 5 status: bit0 rx nonempty, bit1 tx full, bit2 irq_pending, bit3 irq_en (R/W). Writing 1 to bit2 clears pending; set and clear in same cycle: set wins.
- Offsets 6/7: timer count (write loads) / compare (R/W).
- Other offsets: read 0 (io_rd_valid still pulses), writes ignored.
- Timer: prescaler counts 0..PRESCALE-1; on wrap, count increments; tick with count == compare: count → 0, irq_pending ← 1. Software count load same cycle as tick: load wins. irq = irq_pending & irq_en.
- Switches pass a 2-flop synchroniser before use.

## Timing
- Memory path and UART/memory strobes: 0-cycle combinational.
- I/O read: data registered at the access edge; io_rd_valid high for exactly the following cycle, proc_rd_data = registered I/O data while io_rd_valid, else mem_rd_data.
- Back-to-back I/O reads: one result per cycle, valid continuous.
- Register writes visible to a read issued the next cycle.
- Switch change visible to reads after 2 clocks.
- Reset (async, any cycle, including mid-access): leds 0, io_rd_valid 0, registered read data 0, sync flops 0, prescaler 0, count 0, compare all-ones, irq_pending 0, irq_en 0, irq 0. Combinational strobes follow inputs even in reset; pending read is discarded.

## Configuration
- MEM_MAP_IO_TIMER_EN defined: timer, prescaler, offsets 6/7 and status bits 2-3 implemented.
- Undefined: no timer logic; offsets 6/7 read 0 and ignore writes; status bits 2-3 read 0; irq tied 0.

## Test plan
- addr=0x00000010, proc_rd, mem_rd_data=0xBEEF -> mem_rd=1 same cycle, proc_rd_data=0xBEEF, io_rd_valid=0.
- Write 0x00A5 to 0x00800004, read it back -> leds=0xA5 next cycle; readback 0x00A5 with io_rd_valid one cycle after the read.
- uart_rx_count=0, read 0x00800000 -> uart_rd=0, data 0; rx_count=3, uart_rd_data=0x41 -> uart_rd=1 one cycle, data 0x0041.
- uart_tx_count=1024, write 0x00800000 -> uart_wr=0; tx_count=5 -> uart_wr=1, uart_wr_data=proc_wr_data[7:0].
- Timer enabled, PRESCALE=2, compare=3, irq_en=1 -> irq after 8 clocks; write 0x4 to status -> irq drops next cycle; clear coinciding with match -> irq stays 1.
- Assert rst_n=0 mid I/O read with leds=0xFF -> leds=0, io_rd_valid=0, irq=0 immediately, no valid after release.
